// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO pop side and output stream of the FIFO read drain stage
// master: the reader (drives fifo_re, m_data, m_valid); slave: upstream FIFO plus downstream sink.
interface fifo_stream_reader_if #(
  parameter int width = 16
);
  logic             fifo_empty;
  logic [width-1:0] fifo_data;
  logic             fifo_re;
  logic [width-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_re, m_data, m_valid
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_re, m_data, m_valid
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO drain stage with 3-entry skid buffer onto a valid/ready stream
// Optional FIFO_RD_STATS_EN adds a saturating pop_count of accepted words.
module fifo_stream_reader #(
  parameter int width     = 16,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [cnt_width-1:0] pop_count
`endif
);

  if (width < 1 || cnt_width < 1) begin : g_bad_params
    $error("fifo_stream_reader: width and cnt_width must be at least 1");
  end

  logic [width-1:0] mem [3];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [1:0]       occ;
  logic             infl;
  logic             pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign pop         = (occ != 2'd0) && bus.m_ready;
  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = mem[rd_ptr];

  // Counting the in-flight word reserves its slot, so m_ready never reaches fifo_re.
  assign bus.fifo_re = !rst && !bus.fifo_empty && (({1'b0, occ} + {2'b00, infl}) < 3'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
      infl   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else begin
      infl <= bus.fifo_re;
      if (infl) begin
        mem[wr_ptr] <= bus.fifo_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({infl, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(infl && (occ == 2'd3) && !pop));
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_count <= '0;
    end else if (pop && (pop_count != {cnt_width{1'b1}})) begin
      pop_count <= pop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
// Queue-based upstream FIFO, per-cycle model compare, directed cases then random traffic.
module tb_fifo_stream_reader;
  localparam int W    = 16;
  localparam int CW   = 4;
  localparam int LOGN = 8192;

  logic clk = 1'b0;
  logic rst;
  fifo_stream_reader_if #(.width(W)) bus ();
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] pop_count;
`endif

  fifo_stream_reader #(.width(W), .cnt_width(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_RD_STATS_EN
    ,
    .pop_count (pop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] order[$];
  logic [W-1:0] mbuf[$];
  bit           minfl = 1'b0;
  bit           re_prev = 1'b0;
  int           mcnt = 0;

  bit           logv  [LOGN];
  bit           logre [LOGN];
  bit           logpop[LOGN];
  logic [W-1:0] logd  [LOGN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: buffer contents as a queue, in-flight flag, expected accept order.
  always @(negedge clk) begin
    bit           exp_re;
    bit           mpop;
    logic [W-1:0] w;
    exp_re = !rst && !bus.fifo_empty && ((mbuf.size() + int'(minfl)) < 3);
    mpop   = 1'b0;
    chk("fifo_re", bus.fifo_re, exp_re);
    chk("m_valid", bus.m_valid, mbuf.size() != 0);
    if (mbuf.size() != 0) chk("m_data", bus.m_data, mbuf[0]);
`ifdef FIFO_RD_STATS_EN
    chk("pop_count", pop_count, mcnt);
`endif
    re_prev = bus.fifo_re;
    if (rst) begin
      mbuf.delete();
      minfl = 1'b0;
      mcnt  = 0;
    end else begin
      mpop = (mbuf.size() != 0) && bus.m_ready;
      if (mpop) begin
        w = mbuf.pop_front();
        if (order.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL order: word %0h accepted but none expected (cycle %0d)", w, cyc);
        end else begin
          chk("order", w, order.pop_front());
        end
        if (mcnt < (1 << CW) - 1) mcnt++;
      end
      if (minfl) mbuf.push_back(bus.fifo_data);
      minfl = exp_re;
    end
    if (cyc < LOGN) begin
      logv[cyc]   = bus.m_valid;
      logre[cyc]  = bus.fifo_re;
      logpop[cyc] = mpop;
      logd[cyc]   = bus.m_data;
    end
    cyc++;
  end

  // Upstream FIFO: registered data_out one clk after fifo_re, reset with rst.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      fq.delete();
      order.delete();
      bus.fifo_data = '0;
    end else if (re_prev && fq.size() != 0) begin
      bus.fifo_data = fq.pop_front();
    end
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    order.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int t0;
    int t4;
    int n;
    int first;
    rst            = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.m_ready    = 1'b0;
    ticks(2);
    chk("reset_m_valid", bus.m_valid, 0);
    chk("reset_m_data", bus.m_data, 16'h0000);
`ifdef FIFO_RD_STATS_EN
    chk("reset_pop_count", pop_count, 0);
`endif
    rst = 1'b0;

    // Preloaded 1..8, always ready: 8 back-to-back words two clks after first pop.
    bus.m_ready = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 8; k++) push(k[W-1:0]);
    ticks(14);
    chk("t1_first_re", logre[t0], 1);
    chk("t1_no_early_valid", logv[t0+1], 0);
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", logv[t0+2+k], 1);
      chk("t1_data", logd[t0+2+k], k + 1);
    end
    chk("t1_valid_after", logv[t0+10], 0);

    // Stalled sink: exactly three pops, head word held.
    do_reset();
    bus.m_ready = 1'b0;
    t0 = cyc;
    for (int k = 1; k <= 8; k++) push(k[W-1:0]);
    ticks(12);
    n = 0;
    for (int k = 0; k < 12; k++) n += int'(logre[t0+k]);
    chk("t2_re_pulses", n, 3);
    chk("t2_hold_early", logd[t0+2], 16'h0001);
    chk("t2_hold_late", logd[t0+11], 16'h0001);
    chk("t2_hold_valid", logv[t0+11], 1);
    bus.m_ready = 1'b1;
    ticks(15);
    chk("t2_drained", order.size(), 0);

    // Ready toggling 1,0,1,0.
    do_reset();
    t0 = cyc;
    for (int k = 1; k <= 8; k++) push(k[W-1:0]);
    for (int k = 0; k < 30; k++) begin
      bus.m_ready = (k % 2) == 0;
      tick();
    end
    n = 0;
    for (int k = 0; k < 30; k++) n += int'(logpop[t0+k]);
    chk("t3_accepted", n, 8);
    chk("t3_drained", order.size(), 0);

    // Single word in the FIFO.
    do_reset();
    bus.m_ready = 1'b1;
    t0 = cyc;
    push(16'h0044);
    ticks(6);
    n = 0;
    for (int k = 0; k < 6; k++) n += int'(logre[t0+k]);
    chk("t4_re_pulses", n, 1);
    n = 0;
    for (int k = 0; k < 6; k++) n += int'(logv[t0+k]);
    chk("t4_valid_cycles", n, 1);
    chk("t4_data", logd[t0+2], 16'h0044);

    // Reset with two buffered words and one in flight.
    do_reset();
    bus.m_ready = 1'b0;
    t0 = cyc;
    for (int k = 1; k <= 8; k++) push(k[W-1:0]);
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t4 = cyc;
    tick();
    chk("t5_pre_re", {logre[t0], logre[t0+1], logre[t0+2]}, 3'b111);
    chk("t5_valid_after_rst", logv[t4], 0);
    chk("t5_re_after_rst", logre[t4], 0);
    for (int k = 0; k < 4; k++) push(16'h00A1 + k[W-1:0]);
    bus.m_ready = 1'b1;
    ticks(8);
    first = -1;
    for (int k = t4; k < cyc; k++) if (first < 0 && logv[k]) first = k;
    chk("t5_found_word", first >= 0, 1);
    if (first >= 0) chk("t5_first_word", logd[first], 16'h00A1);

`ifdef FIFO_RD_STATS_EN
    // Counter saturation with cnt_width=4.
    do_reset();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 20; k++) push(16'h0100 + k[W-1:0]);
    ticks(30);
    chk("t6_pop_count_sat", pop_count, 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_pop_count_rst", pop_count, 0);
`endif

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 6) push(W'($urandom_range(0, 65535)));
      bus.m_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    bus.m_ready = 1'b1;
    ticks(20);
    chk("rand_drained", order.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
